// File: rtl/carrier_doppler_sweep_if.sv
// Sweep control/status bundle: register file and acquisition side (master), sweeper (slave).
interface carrier_doppler_sweep_if #(
    parameter int BIN_W   = 8,
    parameter int DWELL_W = 16
);
    logic                     start;
    logic                     abort;
    logic [28:0]              f_center;
    logic [28:0]              f_step;
    logic [BIN_W-1:0]         num_bins;
    logic [DWELL_W-1:0]       dwell;
    logic                     dump;
    logic [28:0]              f_control;
    logic signed [BIN_W:0]    bin_offset;
    logic                     bin_done;
    logic                     busy;
    logic                     done;

    modport master (
        output start, abort, f_center, f_step, num_bins, dwell, dump,
        input  f_control, bin_offset, bin_done, busy, done
    );

    modport slave (
        input  start, abort, f_center, f_step, num_bins, dwell, dump,
        output f_control, bin_offset, bin_done, busy, done
    );
endinterface

// File: rtl/carrier_doppler_sweep.sv
// Steps carrier_nco f_control over a Doppler bin grid, discarding the straddling dump after each retune.
// Latency: first word t+2+(N>>1) (t+2 with CARR_SWEEP_ZIGZAG_EN); bin_done t+1 after completing dump.
// No backpressure: dump/start are pulses; start while busy and dump outside SETTLE/DWELL are ignored.
module carrier_doppler_sweep #(
    parameter int BIN_W   = 8,
    parameter int DWELL_W = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    carrier_doppler_sweep_if.slave  sw
);
    typedef enum logic [2:0] {
        S_IDLE, S_PRESET, S_SETTLE, S_DWELL, S_NEXT, S_DONE
    } state_t;

    state_t                 state_q;
    logic [28:0]            f_center_q;
    logic [28:0]            f_step_q;
    logic [28:0]            acc_q;
    logic [28:0]            neg_q;
    logic [28:0]            f_control_q;
    logic [BIN_W-1:0]       bins_q;
    logic [BIN_W-1:0]       bin_idx_q;
    logic [BIN_W-1:0]       preset_cnt_q;
    logic [DWELL_W-1:0]     dwell_q;
    logic [DWELL_W-1:0]     dwell_cnt_q;
    logic signed [BIN_W:0]  bin_offset_q;
    logic                   bin_done_q;
    logic                   busy_q;
    logic                   done_q;

    logic [BIN_W-1:0]       num_bins_d;
    logic [DWELL_W-1:0]     dwell_d;
    logic [BIN_W-1:0]       preset_cnt_d;
    logic [BIN_W:0]         start_off_d;
    logic                   last_bin_d;
    logic                   dwell_hit_d;
    logic                   zz_pos_d;
    logic [28:0]            next_f_d;
    logic [BIN_W:0]         next_off_d;

    always_comb begin
        num_bins_d  = (sw.num_bins == '0) ? BIN_W'(1) : sw.num_bins;
        dwell_d     = (sw.dwell == '0) ? DWELL_W'(1) : sw.dwell;
        last_bin_d  = (bin_idx_q == bins_q - BIN_W'(1));
        dwell_hit_d = (dwell_cnt_q == dwell_q - DWELL_W'(1));
        zz_pos_d    = bin_offset_q[BIN_W] || (bin_offset_q == '0);
`ifdef CARR_SWEEP_ZIGZAG_EN
        // Centre-out: alternate between the upper and lower accumulators.
        preset_cnt_d = '0;
        start_off_d  = '0;
        if (zz_pos_d) begin
            next_f_d   = acc_q + f_step_q;
            next_off_d = (BIN_W+1)'(1) - bin_offset_q;
        end else begin
            next_f_d   = neg_q - f_step_q;
            next_off_d = (BIN_W+1)'(0) - bin_offset_q;
        end
`else
        preset_cnt_d = num_bins_d >> 1;
        start_off_d  = (BIN_W+1)'(0) - {1'b0, bins_q >> 1};
        next_f_d     = acc_q + f_step_q;
        next_off_d   = bin_offset_q + (BIN_W+1)'(1);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            f_center_q   <= '0;
            f_step_q     <= '0;
            acc_q        <= '0;
            neg_q        <= '0;
            f_control_q  <= '0;
            bins_q       <= '0;
            bin_idx_q    <= '0;
            preset_cnt_q <= '0;
            dwell_q      <= '0;
            dwell_cnt_q  <= '0;
            bin_offset_q <= '0;
            bin_done_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            bin_done_q <= 1'b0;
            if (state_q != S_IDLE && sw.abort) begin
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
                done_q      <= 1'b0;
                f_control_q <= f_center_q;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (sw.start && !sw.abort) begin
                            f_center_q   <= sw.f_center;
                            f_step_q     <= sw.f_step;
                            bins_q       <= num_bins_d;
                            dwell_q      <= dwell_d;
                            acc_q        <= sw.f_center;
                            neg_q        <= sw.f_center;
                            preset_cnt_q <= preset_cnt_d;
                            bin_idx_q    <= '0;
                            busy_q       <= 1'b1;
                            state_q      <= S_PRESET;
                        end
                    end
                    S_PRESET: begin
                        if (preset_cnt_q != '0) begin
                            acc_q        <= acc_q - f_step_q;
                            preset_cnt_q <= preset_cnt_q - BIN_W'(1);
                        end else begin
                            f_control_q  <= acc_q;
                            bin_offset_q <= start_off_d;
                            state_q      <= S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        if (sw.dump) begin
                            dwell_cnt_q <= '0;
                            state_q     <= S_DWELL;
                        end
                    end
                    S_DWELL: begin
                        if (sw.dump) begin
                            if (dwell_hit_d) begin
                                bin_done_q <= 1'b1;
                                state_q    <= last_bin_d ? S_DONE : S_NEXT;
                            end else begin
                                dwell_cnt_q <= dwell_cnt_q + DWELL_W'(1);
                            end
                        end
                    end
                    S_NEXT: begin
`ifdef CARR_SWEEP_ZIGZAG_EN
                        if (zz_pos_d) acc_q <= next_f_d;
                        else          neg_q <= next_f_d;
`else
                        acc_q <= next_f_d;
`endif
                        f_control_q  <= next_f_d;
                        bin_offset_q <= next_off_d;
                        bin_idx_q    <= bin_idx_q + BIN_W'(1);
                        state_q      <= S_SETTLE;
                    end
                    S_DONE: begin
                        // Two cycles: raise done, then park and release busy.
                        if (!done_q) begin
                            done_q <= 1'b1;
                        end else begin
                            done_q      <= 1'b0;
                            busy_q      <= 1'b0;
                            f_control_q <= f_center_q;
                            state_q     <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign sw.f_control  = f_control_q;
    assign sw.bin_offset = bin_offset_q;
    assign sw.bin_done   = bin_done_q;
    assign sw.busy       = busy_q;
    assign sw.done       = done_q;
endmodule

// File: doc/carrier_doppler_sweep.md
# carrier_doppler_sweep

Sequences the `f_control` word of `carrier_nco` across a grid of Doppler bins during acquisition. For each bin it retunes the NCO and discards the one integration period that straddles the retune. It then holds the bin for a programmed number of accumulator dump periods and flags completion to the acquisition logic. It sits per channel between the channel register file and `carrier_nco`, and is driven by the channel's dump pulse.

## Interface
- `BIN_W`, 8: width of the bin count.
- `DWELL_W`, 16: width of the dwell count, in dumps.
- `clk`  in  1  system clock (16.368 MHz sample clock).
- `rstn`  in  1  synchronous reset, active-low.
- `start`  in  1  one-cycle request to begin a sweep.
- `abort`  in  1  one-cycle request to stop the sweep.
- `f_center`  in  29  centre carrier word (f = word·Fs/2^30).
- `f_step`  in  29  bin spacing word.
- `num_bins`  in  BIN_W  number of bins; 0 is treated as 1.
- `dwell`  in  DWELL_W  dumps integrated per bin; 0 is treated as 1.
- `dump`  in  1  one-cycle integration-end pulse from the accumulators.
- `f_control`  out  29  registered word to `carrier_nco.f_control`.
- `bin_offset`  out  BIN_W+1  signed offset index of the current bin, in steps.
- `bin_done`  out  1  one-cycle pulse: dwell for the current bin is complete.
- `busy`  out  1  high from the cycle after an accepted `start` until return to IDLE.
- `done`  out  1  one-cycle pulse: all bins completed normally.

## Operation
- `start`, `f_center`, `f_step`, `num_bins` and `dwell` are sampled together when `start` is accepted in IDLE.
- States:
  - IDLE: `start` goes to PRESET.
  - PRESET: runs the start-frequency computation, then goes to SETTLE.
  - SETTLE: one `dump` goes to DWELL; that dump is discarded.
  - DWELL: counts `dump`. On dump number `dwell`, pulses `bin_done` and goes to NEXT, or to DONE if it was the last bin.
  - NEXT: retunes and goes to SETTLE.
  - DONE: pulses `done` and goes to IDLE.
- PRESET:
  - Linear order: subtracts `f_step` from an accumulator loaded with `f_center`, one subtraction per cycle, `num_bins>>1` times.
  - `bin_offset` starts at `-(num_bins>>1)`.
  - Zigzag order: PRESET lasts 1 cycle; the accumulator is `f_center` and `bin_offset` is 0.
- `f_control` is written on PRESET exit and on every NEXT; it is constant otherwise.
- All frequency arithmetic is modulo 2^29 (two's-complement wrap). There is no saturation, so negative Doppler wraps naturally.
- Bin order:
  - Linear: offsets -(N>>1), …, N-1-(N>>1), using +`f_step` per NEXT.
  - Zigzag: offsets 0, +1, -1, +2, -2, …, stopping after N bins. Separate +/− accumulators are kept, so no multiplier is needed.
- `abort` in any non-IDLE state:
  - Next state is IDLE, and `f_control` is parked at the latched `f_center`.
  - No `bin_done` or `done` is issued, including when a completing dump arrives in the same cycle. `abort` wins over all other events.
- On normal DONE, `f_control` is parked at `f_center`.
- `start` while `busy` is ignored. In IDLE, `abort`+`start` in the same cycle does nothing.
- `dump` in IDLE, PRESET or NEXT is ignored.

## Timing
- Reset values:
  - `f_control`=0, `bin_offset`=0, `bin_done`=0, `busy`=0, `done`=0.
  - State is IDLE and all counters are cleared.
- Reset mid-sweep takes effect on the next edge and takes priority over `abort`.
- `start` at cycle t:
  - `busy` is high at t+1.
  - `f_control` is valid at the first bin at t+2+(`num_bins`>>1) for linear order, or t+2 for zigzag.
- Completing dump at cycle t:
  - `bin_done` and `bin_offset` are valid at t+1.
  - For a non-last bin, the new `f_control` and `bin_offset` appear at t+2.
- For the last bin, `done` pulses at t+2, `busy` drops at t+3, and `f_control` is at centre at t+3.
- Total dumps consumed per bin is `dwell`+1.

## Configuration
- `CARR_SWEEP_ZIGZAG_EN` defined: zigzag centre-out bin order, and PRESET lasts 1 cycle.
- Undefined: linear low-to-high order, with the iterative PRESET described above.

## Test plan
- Linear, `f_center`=29'h0800_0000, `f_step`=29'h0000_8021 (≈500 Hz), `num_bins`=5, `dwell`=2, dumps every 16 cycles:
  - `f_control` sequence is 0x07FE_FFBE, 0x07FF_7FDF, 0x0800_0000, 0x0800_8021, 0x0801_0042.
  - 5 `bin_done` pulses, each 3 dumps apart; then `done`; `f_control` returns to 0x0800_0000.
- Zigzag build, same settings: `bin_offset` is 0, +1, -1, +2, -2, and `f_control` matches the corresponding words.
- Wrap: `f_center`=0, `f_step`=1, `num_bins`=3 in linear order: the first word is 29'h1FFF_FFFF, followed by 0 and then 1.
- `abort` in the same cycle as the completing dump of bin 2: no `bin_done`, no `done`; `busy` is low next cycle and `f_control` is back at `f_center`.
- `num_bins`=0 and `dwell`=0: exactly one bin, 2 dumps, then `done`. A second `start` pulsed while `busy` is ignored, with no restart.
- `rstn` low for 1 cycle during DWELL: all outputs are at reset values the next cycle, and a following `start` runs a clean sweep.
